tlc_light_sequencer: RTL
========================

// Module: tlc_light_sequencer
// PURPOSE
//  Downstream of the TLC master: takes its requested direction (dir), runs the safe lamp
//  sequence green -> yellow -> all-red -> green for the new direction, and returns ok
//  ("current green has met minimum time, change allowed") to the master.
//  Drives the lamp heads for the NS, EW and left-turn (LT) approaches.
// PARAMETERS
//  MIN_GREEN   8  cycles a green must be held before ok asserts / a change may start
//  YELLOW_CYC  3  cycles of yellow on the outgoing direction
//  ALLRED_CYC  2  cycles of all-red between yellow and the new green
//  CW          4  phase counter width; each of the 3 timing params must be in 1..2^CW-1
// PORTS
//  clk       in   1  clock
//  rst       in   1  reset, synchronous, active-high
//  dir       in   2  requested direction from master: 00 NS, 01 EW, 10 LT, 11 illegal
//  ok        out  1  1 = granted direction is green and MIN_GREEN elapsed
//  light_ns  out  3  NS lamps {red,yellow,green}, exactly one bit set
//  light_ew  out  3  EW lamps {red,yellow,green}
//  light_lt  out  3  LT lamps {red,yellow,green}
//  cur_dir   out  2  direction currently holding (or yielding) right of way
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=GREEN, cur_dir=00 (NS), tgt=00, cnt=0, ok=0;
//   light_ns=001, light_ew=100, light_lt=100. Reset wins over any pending sequence.
//  Registers: state{GREEN,YELLOW,ALLRED}, cur_dir, tgt, cnt[CW-1:0]. All outputs are
//   Moore (decoded from registers only), no combinational path dir -> ok/lamps.
//  GREEN: cnt increments each cycle, saturating at MIN_GREEN.
//   ok = (state==GREEN) && (cnt==MIN_GREEN).
//   If cnt==MIN_GREEN and dir!=cur_dir and dir!=11: tgt<=dir, cnt<=0, -> YELLOW.
//   dir==11 or dir==cur_dir: stay GREEN. dir change before MIN_GREEN: held, taken at
//   the first cycle cnt==MIN_GREEN if dir still differs then.
//  YELLOW: cur_dir lamp = yellow (010), others red. cnt++; when cnt==YELLOW_CYC-1:
//   cnt<=0, -> ALLRED. Yellow lasts exactly YELLOW_CYC cycles.
//  ALLRED: all lamps 100. cnt++; when cnt==ALLRED_CYC-1: cur_dir<=tgt, cnt<=0, -> GREEN.
//  dir changes during YELLOW/ALLRED are ignored; tgt is fixed at YELLOW entry.
//   If dir then differs from new cur_dir, a fresh sequence follows after MIN_GREEN.
//  Latency: request accepted at edge T -> new green from edge T+YELLOW_CYC+ALLRED_CYC;
//   ok next high MIN_GREEN cycles after green entry. ok drops the cycle YELLOW is entered.
//  Safety invariant: at most one approach non-red in any cycle; never green->green
//   or green->red without yellow. Unreachable state encoding -> reset values next cycle.
//  Counter compare uses CW-bit unsigned; no wrap (saturation in GREEN, bounded in others).
// STRUCTURE
//  Shared package/defines (tlc_defs): direction codes NS/EW/LT (same values the master
//   uses), lamp encodings RED=100 YEL=010 GRN=001, sequencer state codes.
//  One sub-module: tlc_phase_timer (sync clear, enable, saturating CW-bit up-counter,
//   compare-to-value done flag); sequencer FSM + lamp decode in this module.
// TESTING
//  1 reset, dir=00 held 20 cycles -> NS 001, EW/LT 100; ok=0 cycles 0..7, ok=1 from 8 on.
//  2 after ok, dir 00->01 -> ok=0 next cycle; NS 010 for 3 cycles; all 100 for 2; then
//    EW 001, cur_dir=01; ok=1 exactly 8 cycles after EW green entry.
//  3 dir=10 applied 2 cycles after reset -> NS stays green until cnt=8, then yellow; LT
//    green 5 cycles later.
//  4 dir toggles 01->10 during YELLOW -> EW still granted (tgt unchanged); after 8 cycles
//    of EW green a second sequence to LT runs.
//  5 dir=11 for 30 cycles from NS green -> no transition, ok stays 1.
//  6 rst pulsed mid-ALLRED -> next cycle NS 001, others 100, ok=0, cnt restarts;
//    every test asserts the one-non-red and no-skip-yellow invariants each cycle.
//  7 closed loop with TLC master, random car_ew/car_lt -> invariants hold, no deadlock.

Source files
------------

// File: rtl/tlc_light_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// tlc_light_sequencer_pkg
//
// Purpose:
//   Shared definitions for the traffic-light sequencer slice: direction codes
//   (the same values the TLC master drives), lamp-head encodings, sequencer
//   state codes, default timing and a lamp decode helper.
//
// Contents:
//   DIR_*          2-bit direction codes (NS, EW, LT, illegal)
//   lamp_t         3-bit lamp head {red,yellow,green}, always one-hot
//   LAMP_*         red / yellow / green encodings
//   seq_state_t    sequencer FSM states
//   DEF_*          default timing parameters and phase counter width
//   lampFor()      lamp head value for one approach given state and holder
// ---------------------------------------------------------------------------
package tlc_light_sequencer_pkg;

  localparam logic [1:0] DIR_NS  = 2'b00;
  localparam logic [1:0] DIR_EW  = 2'b01;
  localparam logic [1:0] DIR_LT  = 2'b10;
  localparam logic [1:0] DIR_ILL = 2'b11;

  typedef logic [2:0] lamp_t;

  localparam lamp_t LAMP_RED = 3'b100;
  localparam lamp_t LAMP_YEL = 3'b010;
  localparam lamp_t LAMP_GRN = 3'b001;

  // Encoding 2'b11 is deliberately left unused; the FSM recovers from it
  // by returning to its reset values.
  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10
  } seq_state_t;

  // Each timing value must lie in 1..2^CW-1 so that the counter compare
  // values fit in CW bits without wrapping.
  localparam int DEF_MIN_GREEN  = 8;
  localparam int DEF_YELLOW_CYC = 3;
  localparam int DEF_ALLRED_CYC = 2;
  localparam int DEF_CW         = 4;

  // Only the approach holding right of way can ever be non-red, which is
  // what keeps the one-non-red safety property structural rather than
  // something each output has to get right on its own.
  function automatic lamp_t lampFor(seq_state_t st, logic [1:0] holder,
                                    logic [1:0] approach);
    lamp_t l;
    l = LAMP_RED;
    if (approach == holder) begin
      case (st)
        ST_GREEN:  l = LAMP_GRN;
        ST_YELLOW: l = LAMP_YEL;
        default:   l = LAMP_RED;
      endcase
    end
    return l;
  endfunction

endpackage

// File: rtl/tlc_light_sequencer_if.sv
// ---------------------------------------------------------------------------
// tlc_light_sequencer_if
//
// Purpose:
//   Bundle between the TLC master and the light sequencer.
//
// Signals:
//   dir       master -> seq   requested direction (DIR_* codes)
//   ok        seq -> master   granted direction green and minimum time met
//   light_ns  seq -> lamps    NS head {red,yellow,green}
//   light_ew  seq -> lamps    EW head {red,yellow,green}
//   light_lt  seq -> lamps    LT head {red,yellow,green}
//   cur_dir   seq -> master   direction holding (or yielding) right of way
//
// Modports:
//   master    the TLC master side (drives dir)
//   slave     the sequencer side (drives everything else)
// ---------------------------------------------------------------------------
interface tlc_light_sequencer_if;
  import tlc_light_sequencer_pkg::*;

  logic [1:0] dir;
  logic       ok;
  lamp_t      light_ns;
  lamp_t      light_ew;
  lamp_t      light_lt;
  logic [1:0] cur_dir;

  modport master (
    output dir,
    input  ok,
    input  light_ns,
    input  light_ew,
    input  light_lt,
    input  cur_dir
  );

  modport slave (
    input  dir,
    output ok,
    output light_ns,
    output light_ew,
    output light_lt,
    output cur_dir
  );

endinterface

// File: rtl/tlc_light_sequencer_phase_timer.sv
// ---------------------------------------------------------------------------
// tlc_light_sequencer_phase_timer
//
// Purpose:
//   Phase counter for the light sequencer. Synchronous clear, enable, and a
//   CW-bit up-count that saturates at the current compare value, so the
//   count never wraps no matter how long a phase is held.
//
// Ports:
//   clk          in   1   clock
//   rst          in   1   synchronous active-high reset (count -> 0)
//   i_clear      in   1   synchronous clear, wins over enable
//   i_enable     in   1   count enable
//   i_limit      in   CW  compare / saturation value
//   o_countNext  out  CW  value the count takes at the next edge
//   o_done       out  1   current count equals i_limit
// ---------------------------------------------------------------------------
module tlc_light_sequencer_phase_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_enable,
  input  logic [CW-1:0] i_limit,
  output logic [CW-1:0] o_countNext,
  output logic          o_done
);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_countNext;

  // Exposing the next count lets the sequencer register its outputs
  // against the post-edge count instead of lagging them by a cycle.
  always_comb begin
    w_countNext = r_count;
    if (i_clear) begin
      w_countNext = '0;
    end else if (i_enable && (r_count < i_limit)) begin
      w_countNext = r_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_countNext;
    end
  end

  assign o_countNext = w_countNext;
  assign o_done      = (r_count == i_limit);

endmodule

// File: rtl/tlc_light_sequencer.sv
// ---------------------------------------------------------------------------
// tlc_light_sequencer
//
// Purpose:
//   Sits downstream of the TLC master. Takes the requested direction and
//   walks the safe lamp sequence green -> yellow -> all-red -> green for
//   the new direction, reporting back when the current green has been held
//   long enough that a change may start.
//
// Parameters:
//   MIN_GREEN    cycles a green is held before ok / a change may start
//   YELLOW_CYC   cycles of yellow on the outgoing direction
//   ALLRED_CYC   cycles of all-red between yellow and the new green
//   CW           phase counter width; timing values must be in 1..2^CW-1
//
// Ports:
//   clk          in   1   clock
//   rst          in   1   synchronous active-high reset
//   bus          slave modport of tlc_light_sequencer_if
//                  dir in; ok, light_ns/ew/lt, cur_dir out
//
// All outputs are registered; there is no combinational path from dir to
// any output.
// ---------------------------------------------------------------------------
module tlc_light_sequencer
  import tlc_light_sequencer_pkg::*;
#(
  parameter int MIN_GREEN  = DEF_MIN_GREEN,
  parameter int YELLOW_CYC = DEF_YELLOW_CYC,
  parameter int ALLRED_CYC = DEF_ALLRED_CYC,
  parameter int CW         = DEF_CW
) (
  input  logic                 clk,
  input  logic                 rst,
  tlc_light_sequencer_if.slave bus
);

  // Yellow and all-red end on the last counted cycle, so their compare
  // values are one less than the phase length; green saturates at its
  // full minimum so ok can be read straight off the count.
  localparam logic [CW-1:0] L_MIN_GREEN = CW'(MIN_GREEN);
  localparam logic [CW-1:0] L_YEL_LAST  = CW'(YELLOW_CYC - 1);
  localparam logic [CW-1:0] L_AR_LAST   = CW'(ALLRED_CYC - 1);

  seq_state_t  r_state;
  logic [1:0]  r_curDir;
  logic [1:0]  r_tgt;
  logic        r_ok;
  lamp_t       r_lightNs;
  lamp_t       r_lightEw;
  lamp_t       r_lightLt;

  seq_state_t  w_stateNext;
  logic [1:0]  w_curDirNext;
  logic [1:0]  w_tgtNext;
  logic        w_clear;
  logic [CW-1:0] w_limit;
  logic [CW-1:0] w_countNext;
  logic        w_done;

  // Compare value for the phase currently running.
  always_comb begin
    w_limit = L_MIN_GREEN;
    case (r_state)
      ST_GREEN:  w_limit = L_MIN_GREEN;
      ST_YELLOW: w_limit = L_YEL_LAST;
      ST_ALLRED: w_limit = L_AR_LAST;
      default:   w_limit = L_MIN_GREEN;
    endcase
  end

  tlc_light_sequencer_phase_timer #(
    .CW (CW)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_enable    (1'b1),
    .i_limit     (w_limit),
    .o_countNext (w_countNext),
    .o_done      (w_done)
  );

  // Next-state decision. The target is captured only on leaving green, so
  // anything the master does on dir during yellow / all-red is ignored.
  // A request that arrives before the minimum green is simply not acted on
  // yet; it is taken on the first saturated cycle if it is still pending.
  always_comb begin
    w_stateNext  = r_state;
    w_curDirNext = r_curDir;
    w_tgtNext    = r_tgt;
    w_clear      = 1'b0;
    case (r_state)
      ST_GREEN: begin
        if (w_done && (bus.dir != r_curDir) && (bus.dir != DIR_ILL)) begin
          w_tgtNext   = bus.dir;
          w_stateNext = ST_YELLOW;
          w_clear     = 1'b1;
        end
      end
      ST_YELLOW: begin
        if (w_done) begin
          w_stateNext = ST_ALLRED;
          w_clear     = 1'b1;
        end
      end
      ST_ALLRED: begin
        if (w_done) begin
          w_curDirNext = r_tgt;
          w_stateNext  = ST_GREEN;
          w_clear      = 1'b1;
        end
      end
      default: begin
        w_stateNext  = ST_GREEN;
        w_curDirNext = DIR_NS;
        w_tgtNext    = DIR_NS;
        w_clear      = 1'b1;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up
  // with the state register rather than trailing it by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_GREEN;
      r_curDir  <= DIR_NS;
      r_tgt     <= DIR_NS;
      r_ok      <= 1'b0;
      r_lightNs <= LAMP_GRN;
      r_lightEw <= LAMP_RED;
      r_lightLt <= LAMP_RED;
    end else begin
      r_state   <= w_stateNext;
      r_curDir  <= w_curDirNext;
      r_tgt     <= w_tgtNext;
      r_ok      <= (w_stateNext == ST_GREEN) && (w_countNext == L_MIN_GREEN);
      r_lightNs <= lampFor(w_stateNext, w_curDirNext, DIR_NS);
      r_lightEw <= lampFor(w_stateNext, w_curDirNext, DIR_EW);
      r_lightLt <= lampFor(w_stateNext, w_curDirNext, DIR_LT);
    end
  end

  assign bus.ok       = r_ok;
  assign bus.light_ns = r_lightNs;
  assign bus.light_ew = r_lightEw;
  assign bus.light_lt = r_lightLt;
  assign bus.cur_dir  = r_curDir;

endmodule
